mppt_controller: RTL and testbench
==================================

MPPT_CONTROLLER -- requirements
Module: mppt_controller

Interface
REQ-001 The block SHALL provide these parameters:
- STEP, default 4: duty increment per update.
- DUTY_MIN, default 16: lowest legal duty code.
- DUTY_MAX, default 240: highest legal duty code.
- DUTY_INIT, default 128: duty after reset.
- SETTLE_CYCLES, default 16: clocks ignored after each duty change.

REQ-002 The block SHALL provide these ports:
- clk, input, 1: the block's single clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: tracking enable.
- sample_valid, input, 1: v_in and i_in are valid this cycle.
- v_in, input, 8: panel voltage code, unsigned.
- i_in, input, 8: panel current code, unsigned.
- duty, output, 8: duty command to the power-converter stage.
- duty_valid, output, 1: one-cycle pulse marking a new duty value.
- power_out, output, 16: last computed panel power v_in*i_in.
- dir_up, output, 1: current perturbation direction (1 = increasing).
- tracking, output, 1: high when the FSM is not in IDLE.

Function
REQ-003 The block SHALL implement an FSM with the states IDLE, SETTLE, WAIT_SAMPLE, COMPUTE and UPDATE.
REQ-004 IDLE SHALL move to SETTLE on the first cycle enable=1; in every other state, enable=0 SHALL force IDLE on the next edge with duty held.
REQ-005 SETTLE SHALL count SETTLE_CYCLES clocks, then move to WAIT_SAMPLE; sample_valid SHALL be ignored in every state except WAIT_SAMPLE.
REQ-006 In WAIT_SAMPLE, sample_valid=1 at edge N SHALL capture v_in and i_in and enter COMPUTE.
REQ-007 At edge N+1, power_out SHALL load the full 16-bit unsigned product v*i with no truncation, and the FSM SHALL enter UPDATE.
REQ-008 At edge N+2 (UPDATE), the block SHALL apply the perturb-and-observe rule: P > prev keeps dir_up; P < prev inverts dir_up; P == prev keeps dir_up and leaves duty unchanged.
REQ-009 When P != prev, duty SHALL step by STEP in the direction of the resulting dir_up, saturating within [DUTY_MIN, DUTY_MAX].
REQ-010 When a step saturates at a limit, the block SHALL clamp duty to that limit and set dir_up to point away from it, so the next step leaves the limit.
REQ-011 The first sample after entering from IDLE SHALL have no previous value: it only stores prev, and duty steps +STEP with dir_up=1.
REQ-012 In UPDATE, prev SHALL be loaded with P; duty_valid SHALL pulse for exactly one cycle whenever duty changes, and stay low for equal power; the FSM then SHALL enter SETTLE.
REQ-013 Duty update latency SHALL be exactly 2 clocks from sample capture.
REQ-014 If enable falls during COMPUTE or UPDATE, the block SHALL abandon the pending update: duty unchanged, no duty_valid pulse.

Reset
REQ-015 Asserting reset asynchronously SHALL set: state=IDLE, duty=DUTY_INIT, duty_valid=0, power_out=0, prev=0, dir_up=1, tracking=0, settle counter=0, first-sample flag set.
REQ-016 Reset asserted mid-operation SHALL discard any captured sample; after release, the block SHALL stay in IDLE until enable=1.

Structure
REQ-017 Package mppt_pkg SHALL hold the FSM state enum and the default parameter constants (STEP, DUTY_MIN, DUTY_MAX, DUTY_INIT, SETTLE_CYCLES).
REQ-018 A single sub-module, mppt_step_sat, SHALL compute the saturating duty step and the direction-flip-at-limit result combinationally; the multiply and the FSM SHALL stay in the top.

Verification
REQ-019 Reset, enable=1, first sample v=100, i=50 -> power_out=5000, duty 128->132 at +2 clocks, duty_valid pulse, dir_up=1.
REQ-020 Next sample v=100, i=60 (6000>5000) -> duty 136; then v=100, i=40 (4000<6000) -> dir_up=0, duty 132.
REQ-021 Equal power twice (5000, 5000) -> duty unchanged, no duty_valid pulse on the second sample.
REQ-022 Rising power driven until duty=240 -> duty clamps at 240 and dir_up=0; the next increasing-power sample gives duty=236.
REQ-023 sample_valid pulsed during SETTLE -> ignored; enable dropped during COMPUTE -> IDLE, duty unchanged; reset asserted mid-SETTLE -> duty=128 immediately, without waiting for a clock edge.
REQ-024 Extreme operands v=255, i=255 -> power_out=65025, with no overflow.

Source files
------------

// File: rtl/mppt_pkg.sv
// Shared types and default tuning constants for the perturb-and-observe MPPT controller.
package mppt_pkg;

  localparam int DEF_STEP          = 4;
  localparam int DEF_DUTY_MIN      = 16;
  localparam int DEF_DUTY_MAX      = 240;
  localparam int DEF_DUTY_INIT     = 128;
  localparam int DEF_SETTLE_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_SAMPLE,
    COMPUTE,
    UPDATE
  } state_t;

endpackage

// File: rtl/mppt_step_sat.sv
// Combinational duty step with clamping; reaching a limit turns the direction away from it.
module mppt_step_sat #(
  parameter int STEP     = 4,
  parameter int DUTY_MIN = 16,
  parameter int DUTY_MAX = 240
) (
  input  logic [7:0] duty,
  input  logic       dir_up,
  output logic [7:0] duty_next,
  output logic       dir_next
);

  always_comb begin
    duty_next = duty;
    dir_next  = dir_up;
    if (dir_up) begin
      if ({2'b00, duty} + 10'(STEP) >= 10'(DUTY_MAX)) begin
        duty_next = 8'(DUTY_MAX);
        dir_next  = 1'b0;
      end else begin
        duty_next = duty + 8'(STEP);
      end
    end else begin
      // landing exactly on the limit counts as saturating, so the next step leaves it
      if ({2'b00, duty} <= 10'(DUTY_MIN + STEP)) begin
        duty_next = 8'(DUTY_MIN);
        dir_next  = 1'b1;
      end else begin
        duty_next = duty - 8'(STEP);
      end
    end
  end

endmodule

// File: rtl/mppt_controller.sv
// Perturb-and-observe MPPT: settle, sample, multiply, then step duty toward rising power.
// state       | meaning
// IDLE        | tracking disabled, duty held
// SETTLE      | ignoring samples while the converter settles after a duty change
// WAIT_SAMPLE | waiting for sample_valid to capture v_in/i_in
// COMPUTE     | loading power_out with v*i
// UPDATE      | comparing against prev and stepping duty
module mppt_controller
  import mppt_pkg::*;
#(
  parameter int STEP          = DEF_STEP,
  parameter int DUTY_MIN      = DEF_DUTY_MIN,
  parameter int DUTY_MAX      = DEF_DUTY_MAX,
  parameter int DUTY_INIT     = DEF_DUTY_INIT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [7:0]  v_in,
  input  logic [7:0]  i_in,
  output logic [7:0]  duty,
  output logic        duty_valid,
  output logic [15:0] power_out,
  output logic        dir_up,
  output logic        tracking
);

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [7:0]  v_cap;
  logic [7:0]  i_cap;
  logic [15:0] prev;
  logic [15:0] settle_cnt;
  logic        first;
  logic        step_dir;
  logic [7:0]  sat_duty;
  logic        sat_dir;

  // the first sample after IDLE has no reference, so it always probes upward
  assign step_dir = first ? 1'b1 : ((power_out < prev) ? ~dir_up : dir_up);

  mppt_step_sat #(
    .STEP    (STEP),
    .DUTY_MIN(DUTY_MIN),
    .DUTY_MAX(DUTY_MAX)
  ) u_step_sat (
    .duty     (duty),
    .dir_up   (step_dir),
    .duty_next(sat_duty),
    .dir_next (sat_dir)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      duty       <= 8'(DUTY_INIT);
      duty_valid <= 1'b0;
      power_out  <= '0;
      prev       <= '0;
      dir_up     <= 1'b1;
      tracking   <= 1'b0;
      settle_cnt <= '0;
      first      <= 1'b1;
      v_cap      <= '0;
      i_cap      <= '0;
    end else begin
      duty_valid <= 1'b0;
      if (state != IDLE && !enable) begin
        state    <= IDLE;
        tracking <= 1'b0;
        first    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (enable) begin
              state      <= SETTLE;
              tracking   <= 1'b1;
              settle_cnt <= SETTLE_LOAD;
              first      <= 1'b1;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) state <= WAIT_SAMPLE;
            else settle_cnt <= settle_cnt - 16'd1;
          end
          WAIT_SAMPLE: begin
            if (sample_valid) begin
              v_cap <= v_in;
              i_cap <= i_in;
              state <= COMPUTE;
            end
          end
          COMPUTE: begin
            power_out <= 16'(v_cap) * 16'(i_cap);
            state     <= UPDATE;
          end
          UPDATE: begin
            prev  <= power_out;
            first <= 1'b0;
            if (first || power_out != prev) begin
              duty       <= sat_duty;
              dir_up     <= sat_dir;
              duty_valid <= (sat_duty != duty);
            end
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_controller.sv
// Directed and randomized checks of mppt_controller against an arithmetic P&O reference model.
module tb_mppt_controller;

  localparam int STEP     = 4;
  localparam int DUTY_MIN = 16;
  localparam int DUTY_MAX = 240;
  localparam int DUTY_INI = 128;
  localparam int SETTLE   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [7:0]  v_in;
  logic [7:0]  i_in;
  logic [7:0]  duty;
  logic        duty_valid;
  logic [15:0] power_out;
  logic        dir_up;
  logic        tracking;

  int checks = 0;
  int errors = 0;

  int m_duty;
  int m_prev;
  bit m_dir;
  bit m_first;

  mppt_controller #(
    .STEP(STEP), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .DUTY_INIT(DUTY_INI), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .v_in(v_in), .i_in(i_in), .duty(duty), .duty_valid(duty_valid),
    .power_out(power_out), .dir_up(dir_up), .tracking(tracking)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_duty  = DUTY_INI;
    m_prev  = 0;
    m_dir   = 1'b1;
    m_first = 1'b1;
  endfunction

  // P&O rule in plain arithmetic: returns whether the duty moved
  function automatic bit model_sample(input int p);
    int old = m_duty;
    bit move = m_first || (p != m_prev);
    if (!m_first && p < m_prev) m_dir = ~m_dir;
    if (m_first) m_dir = 1'b1;
    if (move) begin
      if (m_dir) m_duty = m_duty + STEP;
      else       m_duty = m_duty - STEP;
      if (m_duty >= DUTY_MAX) begin m_duty = DUTY_MAX; m_dir = 1'b0; end
      if (m_duty <= DUTY_MIN) begin m_duty = DUTY_MIN; m_dir = 1'b1; end
    end
    m_prev  = p;
    m_first = 1'b0;
    return m_duty != old;
  endfunction

  task automatic enter();
    enable = 1'b1;
    @(posedge clk); #1;
    chk("tracking_on", tracking, 1);
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  // precondition: DUT is in WAIT_SAMPLE for the coming edge
  task automatic do_sample(input int v, input int i);
    int  old_duty = m_duty;
    bit  exp_valid;
    sample_valid = 1'b1;
    v_in = 8'(v);
    i_in = 8'(i);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    v_in = 8'($urandom);
    i_in = 8'($urandom);
    @(posedge clk); #1;
    chk("power", power_out, v * i);
    chk("duty_n1", duty, old_duty);
    chk("valid_n1", duty_valid, 0);
    exp_valid = model_sample(v * i);
    @(posedge clk); #1;
    chk("duty_n2", duty, m_duty);
    chk("valid_n2", duty_valid, exp_valid);
    chk("dir", dir_up, m_dir);
  endtask

  // walks SETTLE; optionally injects a sample that must be ignored
  task automatic settle_wait(input bit junk);
    logic [15:0] p_hold = power_out;
    for (int k = 0; k < SETTLE; k++) begin
      if (junk && k == 5) begin
        sample_valid = 1'b1;
        v_in = 8'd255;
        i_in = 8'd255;
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      if (k == 0) chk("valid_one_cycle", duty_valid, 0);
    end
    if (junk) chk("settle_ignore", power_out, p_hold);
  endtask

  task automatic sample_and_settle(input int v, input int i);
    do_sample(v, i);
    settle_wait(1'b0);
  endtask

  initial begin
    int v, i, lv, li;
    reset = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    v_in = '0;
    i_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", duty, DUTY_INI);
    chk("rst_valid", duty_valid, 0);
    chk("rst_power", power_out, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_tracking", tracking, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_hold", tracking, 0);

    enter();
    do_sample(100, 50);
    chk("first_power", power_out, 5000);
    chk("first_duty", duty, 132);
    settle_wait(1'b0);
    sample_and_settle(100, 60);
    chk("rise_duty", duty, 136);
    do_sample(100, 40);
    chk("fall_duty", duty, 132);
    chk("fall_dir", dir_up, 0);
    settle_wait(1'b0);
    sample_and_settle(100, 50);
    do_sample(100, 50);
    chk("equal_no_pulse", duty_valid, 0);
    settle_wait(1'b1);

    sample_and_settle(100, 10);
    i = 11;
    while (m_duty != DUTY_MAX && i < 60) begin
      sample_and_settle(200, i);
      i++;
    end
    chk("clamp_max", duty, 240);
    chk("clamp_dir", dir_up, 0);
    do_sample(200, i);
    chk("leave_max", duty, 236);
    settle_wait(1'b1);

    sample_valid = 1'b1;
    v_in = 8'd10;
    i_in = 8'd10;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_tracking", tracking, 0);
    chk("abort_duty1", duty, m_duty);
    @(posedge clk); #1;
    chk("abort_duty2", duty, m_duty);
    chk("abort_valid", duty_valid, 0);
    m_first = 1'b1;

    enter();
    do_sample(255, 255);
    chk("max_power", power_out, 65025);
    settle_wait(1'b0);
    sample_and_settle(3, 7);

    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_duty", duty, DUTY_INI);
    chk("async_rst_track", tracking, 0);
    chk("async_rst_power", power_out, 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", tracking, 0);
    chk("post_rst_duty", duty, DUTY_INI);

    enter();
    lv = 0;
    li = 0;
    for (int n = 0; n < 30; n++) begin
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        v = lv;
        i = li;
      end else begin
        v = $urandom_range(0, 255);
        i = $urandom_range(0, 255);
      end
      do_sample(v, i);
      settle_wait(1'($urandom_range(0, 1)));
      lv = v;
      li = i;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
